// File: rtl/ctrl_pkg.sv
// Shared control types for the audio serial path: operating word, WS channel
// state and the slot-length constants used by the Tx serializer.
package ctrl_pkg;

    typedef enum logic { I2S = 1'b0, MSB = 1'b1 } standard_t;
    typedef enum logic { f16bits = 1'b0, f32bits = 1'b1 } frame_size_t;
    typedef enum logic { MASTER = 1'b0, SLAVE = 1'b1 } mode_t;
    typedef enum logic [1:0] { IDLE = 2'd0, L = 2'd1, R = 2'd2 } ws_state_t;

    typedef struct packed {
        mode_t       mode;
        standard_t   standard;
        frame_size_t frame_size;
        logic        stop;
    } OP_t;

    localparam int F16_N = 16;
    localparam int F32_N = 32;

endpackage

// File: rtl/tx_slot_counter.sv
// Bit index within the current L/R slot and slot-start detection; all state
// moves on the falling edge of the serial bit clock.
module tx_slot_counter
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_,
    input  ws_state_t   ws_state,
    input  logic        stop,
    input  frame_size_t frame_size,
    output logic        slot_start
);

    logic [4:0] cnt_q, cnt_d;
    ws_state_t  prev_q, prev_d;
    logic       n16_q, n16_d;
    logic       active, changed, wrapped, is16_cur;
    logic [4:0] idx, idx_last;

    always_comb begin
        active   = (ws_state == L) || (ws_state == R);
        changed  = (ws_state != prev_q);
        wrapped  = n16_q ? (cnt_q[3:0] == 4'd0) : (cnt_q == 5'd0);
        // a state change and a wrap on the same cycle is one start
        slot_start = rst_ && active && !stop && (changed || wrapped);

        // a new slot uses the frame size presented at its start
        is16_cur = slot_start ? (frame_size == f16bits) : n16_q;
        idx      = changed ? 5'd0 : cnt_q;
        idx_last = is16_cur ? 5'(F16_N - 1) : 5'(F32_N - 1);

        cnt_d  = cnt_q;
        prev_d = prev_q;
        n16_d  = n16_q;
        if (ws_state == IDLE)
            cnt_d = 5'd0;
        else if (!stop)
            cnt_d = (idx == idx_last) ? 5'd0 : idx + 5'd1;
        if (!stop)
            prev_d = ws_state;
        if (slot_start)
            n16_d = (frame_size == f16bits);
    end

    always_ff @(negedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt_q  <= 5'd0;
            prev_q <= IDLE;
            n16_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            prev_q <= prev_d;
            n16_q  <= n16_d;
        end
    end

endmodule

// File: rtl/tx_serializer.sv
// Tx FIFO word to serial data: loads one word per slot, shifts MSB first and
// aligns the stream for MSB-justified or I2S (one-bit delayed) timing.
module tx_serializer
    import ctrl_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_,
    input  OP_t           OP,
    input  ws_state_t     ws_state,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_valid,
    output logic          tx_pop,
    output logic          sd,
    output logic          underrun
);

    logic        slot_start;
    logic        active, sd_pre;
    logic [31:0] word;
    logic [31:0] shift_q, shift_d;
    logic        dly_q, dly_d;
    logic        mode_unused;

    assign mode_unused = OP.mode;

    tx_slot_counter u_cnt (
        .clk        (clk),
        .rst_       (rst_),
        .ws_state   (ws_state),
        .stop       (OP.stop),
        .frame_size (OP.frame_size),
        .slot_start (slot_start)
    );

    always_comb begin
        active = (ws_state == L) || (ws_state == R);

        // an empty FIFO at slot start sends an all-zero slot
        word = 32'h0;
        if (tx_valid)
            word = (OP.frame_size == f16bits) ? {tx_data[15:0], 16'h0000} : tx_data[31:0];

        shift_d = shift_q;
        if (!active)
            shift_d = 32'h0;
        else if (slot_start)
            shift_d = word << 1;
        else if (!OP.stop)
            shift_d = shift_q << 1;

        sd_pre = 1'b0;
        if (active)
            sd_pre = slot_start ? word[31] : shift_q[31];

        // the delay register doubles as the held bit while stopped
        dly_d = OP.stop ? dly_q : sd_pre;

        sd = 1'b0;
        if (rst_)
            sd = (OP.standard == MSB && !OP.stop) ? sd_pre : dly_q;

        tx_pop   = slot_start && tx_valid;
        underrun = slot_start && !tx_valid;
    end

    always_ff @(negedge clk or negedge rst_) begin
        if (!rst_) begin
            shift_q <= 32'h0;
            dly_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            dly_q   <= dly_d;
        end
    end

endmodule

// File: tb/tb_tx_serializer.sv
// Bench for tx_serializer: per-cycle stimulus feeds a bit-queue slot model;
// a monitor compares sd/tx_pop/underrun each cycle against the queued result.
module tb_tx_serializer;
    import ctrl_pkg::*;

    logic        clk;
    logic        rst_;
    OP_t         op;
    ws_state_t   ws_state;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_pop, sd, underrun;

    tx_serializer #(.DW(32)) dut (
        .clk      (clk),
        .rst_     (rst_),
        .OP       (op),
        .ws_state (ws_state),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_pop   (tx_pop),
        .sd       (sd),
        .underrun (underrun)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic sd;
        logic pop;
        logic und;
        int   cyc;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] fifo[$];
    int          tests = 0;
    int          fails = 0;
    int          cycle_no = 0;

    // reference model: the current slot is a queue of bits still to be sent
    ws_state_t m_prev;
    int        m_pos, m_n;
    bit        m_bits[$];
    bit        m_last;

    task automatic model_reset();
        m_prev = IDLE;
        m_pos  = 0;
        m_n    = 32;
        m_bits.delete();
        m_last = 1'b0;
    endtask

    task automatic cyc(input bit rst_v, input ws_state_t ws, input bit stop,
                       input frame_size_t fs, input standard_t std);
        exp_t        e;
        bit          pre;
        logic [31:0] w;
        @(negedge clk);
        #1;
        rst_          = rst_v;
        ws_state      = ws;
        op.stop       = stop;
        op.frame_size = fs;
        op.standard   = std;
        tx_valid      = (fifo.size() > 0);
        tx_data       = tx_valid ? fifo[0] : $urandom;
        e.sd = 1'b0; e.pop = 1'b0; e.und = 1'b0; e.cyc = cycle_no;
        if (!rst_v) begin
            model_reset();
        end else if (stop) begin
            e.sd = m_last;
        end else begin
            pre = 1'b0;
            if (ws == IDLE) begin
                m_bits.delete();
                m_pos = 0;
            end else begin
                if (ws != m_prev || m_pos >= m_n) begin
                    m_n = (fs == f16bits) ? 16 : 32;
                    w   = 32'h0;
                    if (tx_valid) w = fifo.pop_front();
                    e.pop = tx_valid;
                    e.und = !tx_valid;
                    m_bits.delete();
                    for (int i = m_n - 1; i >= 0; i--) m_bits.push_back(w[i]);
                    m_pos = 0;
                end
                pre = m_bits.pop_front();
                m_pos++;
            end
            e.sd   = (std == MSB) ? pre : m_last;
            m_last = pre;
            m_prev = ws;
        end
        expq.push_back(e);
        cycle_no++;
    endtask

    task automatic run(input int n, input ws_state_t ws, input frame_size_t fs,
                       input standard_t std);
        for (int i = 0; i < n; i++) cyc(1'b1, ws, 1'b0, fs, std);
    endtask

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                tests++;
                if (sd !== e.sd || tx_pop !== e.pop || underrun !== e.und) begin
                    fails++;
                    $display("FAIL stream cyc=%0d sd/pop/und got %b%b%b expected %b%b%b",
                             e.cyc, sd, tx_pop, underrun, e.sd, e.pop, e.und);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout waiting for stimulus to complete");
        $fatal(1, "timeout");
    end

    initial begin
        frame_size_t fs, fsc;
        standard_t   std;
        bit          mono, abort;
        rst_ = 1'b0; ws_state = IDLE; tx_data = 32'h0; tx_valid = 1'b0;
        op.mode = MASTER; op.standard = MSB; op.frame_size = f32bits; op.stop = 1'b0;
        model_reset();

        // reset state
        for (int i = 0; i < 3; i++) cyc(1'b0, IDLE, 1'b0, f32bits, MSB);

        // MSB f32 stereo
        fifo.push_back(32'hA5A5_0F0F); fifo.push_back(32'h8000_0001);
        run(2, IDLE, f32bits, MSB); run(32, L, f32bits, MSB);
        run(32, R, f32bits, MSB);   run(2, IDLE, f32bits, MSB);

        // I2S f16 stereo: final LSB shows up after R->IDLE
        fifo.push_back(32'hFFFF_C003); fifo.push_back(32'h0000_0001);
        run(16, L, f16bits, I2S); run(16, R, f16bits, I2S); run(3, IDLE, f16bits, I2S);

        // empty FIFO at L start, data arrives mid-slot
        run(10, L, f32bits, MSB);
        fifo.push_back(32'h1234_5678);
        run(22, L, f32bits, MSB); run(32, R, f32bits, MSB); run(2, IDLE, f32bits, MSB);

        // stop for 5 cycles at index 7
        fifo.push_back(32'hDEAD_BEEF); fifo.push_back(32'h0F1E_2D3C);
        run(7, L, f32bits, MSB);
        for (int i = 0; i < 5; i++) cyc(1'b1, L, 1'b1, f32bits, MSB);
        run(25, L, f32bits, MSB); run(32, R, f32bits, MSB); run(2, IDLE, f32bits, MSB);

        // mono f16, three words back to back
        fifo.push_back(32'h0000_8001); fifo.push_back(32'h0000_7FFE); fifo.push_back(32'h0000_AAAA);
        run(48, L, f16bits, MSB); run(2, IDLE, f16bits, MSB);

        // reset at index 10, then a fresh slot
        fifo.push_back(32'hCAFE_F00D); fifo.push_back(32'h1357_9BDF);
        run(10, L, f32bits, I2S);
        cyc(1'b0, L, 1'b0, f32bits, I2S); cyc(1'b0, L, 1'b0, f32bits, I2S);
        run(2, IDLE, f32bits, I2S); run(32, L, f32bits, I2S); run(2, IDLE, f32bits, I2S);

        // randomized frames
        fifo.delete();
        for (int k = 0; k < 30; k++) begin
            fs   = ($urandom_range(1) == 0) ? f16bits : f32bits;
            std  = ($urandom_range(1) == 0) ? I2S : MSB;
            mono = ($urandom_range(3) == 0);
            abort = 1'b0;
            for (int ch = 0; ch < 2 && !abort; ch++) begin
                for (int i = 0; i < ((fs == f16bits) ? 16 : 32); i++) begin
                    if ($urandom_range(5) == 0 && fifo.size() < 4) fifo.push_back($urandom);
                    fsc = ($urandom_range(31) == 0) ? ((fs == f16bits) ? f32bits : f16bits) : fs;
                    cyc(1'b1, (ch == 1 && !mono) ? R : L, ($urandom_range(15) == 0), fsc, std);
                    if ($urandom_range(79) == 0) begin
                        abort = 1'b1;
                        break;
                    end
                end
            end
            if (abort || $urandom_range(3) == 0) run($urandom_range(3, 1), IDLE, fs, std);
            if ($urandom_range(11) == 0) cyc(1'b0, IDLE, 1'b0, fs, std);
        end
        run(3, IDLE, f32bits, MSB);

        @(posedge clk);
        @(negedge clk);
        tests++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL drain pending=%0d expected 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
